// File: rtl/timer_count_core_if.sv
// Bundles the keypad/pulse/start inputs and the display/status outputs of
// the countdown core.
//   i_pls_1k    : 1-cycle pulse at 1 kHz
//   i_key_valid : 1-cycle strobe qualifying i_bcd_data
//   i_bcd_data  : key code, 0-9 digit, 5'h0A clear, others ignored
//   i_start     : run/pause slide switch (asynchronous level)
//   o_bcd8d     : display word HH:MM:SS:cc, two BCD nibbles per field
//   o_fin       : high while the countdown has finished
//   o_state     : 00 SET, 01 RUN, 10 PAUSE, 11 DONE
interface timer_count_core_if;
    logic        i_pls_1k;
    logic        i_key_valid;
    logic [4:0]  i_bcd_data;
    logic        i_start;
    logic [31:0] o_bcd8d;
    logic        o_fin;
    logic [1:0]  o_state;

    modport master (
        output i_pls_1k, i_key_valid, i_bcd_data, i_start,
        input  o_bcd8d, o_fin, o_state
    );

    modport slave (
        input  i_pls_1k, i_key_valid, i_bcd_data, i_start,
        output o_bcd8d, o_fin, o_state
    );
endinterface

// File: rtl/timer_count_core.sv
// Countdown engine: builds an HH:MM:SS setting from decoded keys, counts it
// down in centiseconds paced by the 1 kHz pulse, drives the 8-digit BCD
// display word and flags completion.
// Ports:
//   i_clk  : system clock
//   i_rstn : asynchronous active-low reset
//   bus    : timer_count_core_if.slave (keys, pulse, start, display, status)
//
// state | meaning
// ------+-----------------------------------------------------------
// SET   | keys build the setting, start rise launches a non-zero count
// RUN   | count decrements one centisecond every TICK_DIV pulses
// PAUSE | count and prescaler frozen, rise resumes, clear key aborts
// DONE  | count reached zero, o_fin high until a key or start fall
module timer_count_core #(
    parameter int TICK_DIV = 10
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    timer_count_core_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_SET   = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [7:0] PRE_TC  = 8'(TICK_DIV - 1);
    localparam logic [4:0] KEY_CLR = 5'h0A;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  pre_q, pre_d;
    logic        fin_q, fin_d;
    logic        start_s1_q, start_s2_q, start_s3_q;
    logic        rise, fall;

    // Decrement one two-digit BCD field; bit 8 of the result is the borrow
    // out, in which case the field wraps to 'wrap'.
    function automatic logic [8:0] dec_field(input logic [7:0] f, input logic [7:0] wrap);
        logic [8:0] r;
        if (f[3:0] != 4'd0)
            r = {1'b0, f[7:4], f[3:0] - 4'd1};
        else if (f[7:4] != 4'd0)
            r = {1'b0, f[7:4] - 4'd1, 4'd9};
        else
            r = {1'b1, wrap};
        return r;
    endfunction

    function automatic logic [31:0] bcd_dec(input logic [31:0] v);
        logic [31:0] r;
        logic [8:0]  f;
        r = v;
        f = dec_field(v[7:0], 8'h99);
        r[7:0] = f[7:0];
        if (f[8]) begin
            f = dec_field(v[15:8], 8'h59);
            r[15:8] = f[7:0];
            if (f[8]) begin
                f = dec_field(v[23:16], 8'h59);
                r[23:16] = f[7:0];
                if (f[8]) begin
                    // HH never underflows: RUN always holds a non-zero count.
                    f = dec_field(v[31:24], 8'h00);
                    r[31:24] = f[7:0];
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] clamp59(input logic [7:0] f);
        return (f > 8'h59) ? 8'h59 : f;
    endfunction

    assign rise = start_s2_q & ~start_s3_q;
    assign fall = ~start_s2_q & start_s3_q;

    always_comb begin
        logic [31:0] set_v;
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        set_v   = cnt_q;
        case (state_q)
            ST_SET: begin
                // Key is applied before the start check so a same-cycle rise
                // sees the updated setting.
                if (bus.i_key_valid) begin
                    if (bus.i_bcd_data < 5'd10)
                        set_v = {cnt_q[27:8], bus.i_bcd_data[3:0], 8'h00};
                    else if (bus.i_bcd_data == KEY_CLR)
                        set_v = 32'h0;
                end
                cnt_d = set_v;
                if (rise && (set_v[31:8] != 24'h0)) begin
                    cnt_d   = {set_v[31:24], clamp59(set_v[23:16]), clamp59(set_v[15:8]), 8'h00};
                    pre_d   = 8'h0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.i_pls_1k) begin
                    if (pre_q >= PRE_TC) begin
                        pre_d = 8'h0;
                        cnt_d = bcd_dec(cnt_q);
                        if (cnt_d == 32'h0)
                            state_d = ST_DONE;
                    end else begin
                        pre_d = pre_q + 8'd1;
                    end
                end
                if (fall && (state_d != ST_DONE))
                    state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (bus.i_key_valid && (bus.i_bcd_data == KEY_CLR)) begin
                    cnt_d   = 32'h0;
                    state_d = ST_SET;
                end else if (rise) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.i_key_valid || fall) begin
                    cnt_d   = 32'h0;
                    state_d = ST_SET;
                end
            end
            default: state_d = ST_SET;
        endcase
        fin_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ST_SET;
            cnt_q      <= 32'h0;
            pre_q      <= 8'h0;
            fin_q      <= 1'b0;
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
            start_s3_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            fin_q      <= fin_d;
            start_s1_q <= bus.i_start;
            start_s2_q <= start_s1_q;
            start_s3_q <= start_s2_q;
        end
    end

    assign bus.o_bcd8d = cnt_q;
    assign bus.o_fin   = fin_q;
    assign bus.o_state = state_q;

endmodule
